// File: rtl/interp_fetch_pkg.sv
// Shared geometry and fixed-point parameters for the rectification pipeline,
// plus the neighbour-fetch FSM state encoding.
package interp_fetch_pkg;

  localparam int D_width = 6;
  localparam int IMG_W   = 640;
  localparam int IMG_H   = 480;
  localparam int XW      = 10;
  localparam int YW      = 9;
  localparam int AW      = 19;

  typedef enum logic [2:0] {
    IDLE,
    RD0,
    RD1,
    RD2,
    RD3,
    CAP,
    OUT
  } fetch_state_e;

endpackage

// File: rtl/interp_fetch_addr.sv
// Clamps an integer coordinate to the frame, picks the x0/x1 column and the
// y0/y1 row, and forms the linear frame-memory address row*IMG_W+col.
module interp_fetch_addr
  import interp_fetch_pkg::*;
(
  input  logic [XW-1:0] i_xi,
  input  logic [YW-1:0] i_yi,
  input  logic          i_sel_x1,
  input  logic          i_sel_y1,
  output logic [AW-1:0] o_addr
);

  localparam logic [XW-1:0] X_MAX = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - 1);

  logic [XW-1:0] w_x0;
  logic [XW-1:0] w_x1;
  logic [YW-1:0] w_y0;
  logic [YW-1:0] w_y1;
  logic [XW-1:0] w_col;
  logic [YW-1:0] w_row;

  assign w_x0 = (i_xi > X_MAX) ? X_MAX : i_xi;
  assign w_y0 = (i_yi > Y_MAX) ? Y_MAX : i_yi;

  // The right/bottom neighbour folds back onto the edge pixel.
  assign w_x1 = (w_x0 == X_MAX) ? X_MAX : w_x0 + XW'(1);
  assign w_y1 = (w_y0 == Y_MAX) ? Y_MAX : w_y0 + YW'(1);

  assign w_col  = i_sel_x1 ? w_x1 : w_x0;
  assign w_row  = i_sel_y1 ? w_y1 : w_y0;
  assign o_addr = AW'(w_row) * AW'(IMG_W) + AW'(w_col);

endmodule

// File: rtl/interp_fetch.sv
// Neighbour-fetch front end: reads the 2x2 pixel neighbourhood of each source
// coordinate from a synchronous-read frame memory and hands it to the interpolator.
module interp_fetch
  import interp_fetch_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  coord_valid,
  output logic                  coord_ready,
  input  logic                  coord_last,
  input  logic [XW+D_width-1:0] coord_x,
  input  logic [YW+D_width-1:0] coord_y,
  output logic [AW-1:0]         mem_addr,
  output logic                  mem_rd,
  input  logic [7:0]            mem_data,
  input  logic                  out_en,
  output logic                  dout_valid,
  output logic                  dout_last,
  output logic [D_width-1:0]    dx,
  output logic [D_width-1:0]    dy,
  output logic [7:0]            lu,
  output logic [7:0]            ru,
  output logic [7:0]            ld,
  output logic [7:0]            rd
);

  fetch_state_e       r_state;
  fetch_state_e       w_next;
  logic               r_run;
  logic [XW-1:0]      r_xi;
  logic [YW-1:0]      r_yi;
  logic [AW-1:0]      r_mem_addr;
  logic               r_dout_valid;
  logic               r_dout_last;
  logic [D_width-1:0] r_dx;
  logic [D_width-1:0] r_dy;
  logic [7:0]         r_lu;
  logic [7:0]         r_ru;
  logic [7:0]         r_ld;
  logic [7:0]         r_rd;

  logic               w_accept;
  logic               w_sel_x1;
  logic               w_sel_y1;
  logic               w_load_addr;
  logic [XW-1:0]      w_xi;
  logic [YW-1:0]      w_yi;
  logic [AW-1:0]      w_addr;

  // r_run keeps coord_ready low until the first clock after reset release.
  assign coord_ready = r_run && (r_state == IDLE);
  assign mem_rd      = (r_state inside {RD0, RD1, RD2, RD3});
  assign w_accept    = coord_ready && coord_valid;

  // The address register is loaded one cycle ahead of each read, so the
  // accept cycle addresses straight from the incoming coordinate.
  assign w_xi = (r_state == IDLE) ? coord_x[XW+D_width-1 -: XW] : r_xi;
  assign w_yi = (r_state == IDLE) ? coord_y[YW+D_width-1 -: YW] : r_yi;

  interp_fetch_addr u_addr (
    .i_xi     (w_xi),
    .i_yi     (w_yi),
    .i_sel_x1 (w_sel_x1),
    .i_sel_y1 (w_sel_y1),
    .o_addr   (w_addr)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_run   <= 1'b1;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_next   = r_state;
    w_sel_x1 = 1'b0;
    w_sel_y1 = 1'b0;
    case (r_state)
      IDLE: if (w_accept) w_next = RD0;
      RD0: begin
        w_next   = RD1;
        w_sel_x1 = 1'b1;
      end
      RD1: begin
        w_next   = RD2;
        w_sel_y1 = 1'b1;
      end
      RD2: begin
        w_next   = RD3;
        w_sel_x1 = 1'b1;
        w_sel_y1 = 1'b1;
      end
      RD3:     w_next = CAP;
      CAP:     w_next = OUT;
      OUT:     if (out_en) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign w_load_addr = (w_next inside {RD0, RD1, RD2, RD3});

  // NOTE: the datapath is plain registers, not a memory array, so all of it is
  // reset; every output must read 0 during reset and after an aborted fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xi         <= '0;
      r_yi         <= '0;
      r_mem_addr   <= '0;
      r_dout_valid <= 1'b0;
      r_dout_last  <= 1'b0;
      r_dx         <= '0;
      r_dy         <= '0;
      r_lu         <= '0;
      r_ru         <= '0;
      r_ld         <= '0;
      r_rd         <= '0;
    end else begin
      r_dout_valid <= (w_next == OUT);
      if (w_load_addr) r_mem_addr <= w_addr;
      if (w_accept) begin
        r_xi        <= coord_x[XW+D_width-1 -: XW];
        r_yi        <= coord_y[YW+D_width-1 -: YW];
        r_dx        <= coord_x[D_width-1:0];
        r_dy        <= coord_y[D_width-1:0];
        r_dout_last <= coord_last;
      end
      // Read data trails its strobe by one cycle.
      case (r_state)
        RD1:     r_lu <= mem_data;
        RD2:     r_ru <= mem_data;
        RD3:     r_ld <= mem_data;
        CAP:     r_rd <= mem_data;
        default: ;
      endcase
    end
  end

  assign mem_addr   = r_mem_addr;
  assign dout_valid = r_dout_valid;
  assign dout_last  = r_dout_last;
  assign dx         = r_dx;
  assign dy         = r_dy;
  assign lu         = r_lu;
  assign ru         = r_ru;
  assign ld         = r_ld;
  assign rd         = r_rd;

endmodule

// File: tb/tb_interp_fetch.sv
// Scoreboard bench for interp_fetch: a driver pushes expected reads and
// neighbour sets from a reference model; a negedge monitor pops and compares.
module tb_interp_fetch;
  import interp_fetch_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  coord_valid = 1'b0;
  logic                  coord_ready;
  logic                  coord_last = 1'b0;
  logic [XW+D_width-1:0] coord_x = '0;
  logic [YW+D_width-1:0] coord_y = '0;
  logic [AW-1:0]         mem_addr;
  logic                  mem_rd;
  logic [7:0]            mem_data = '0;
  logic                  out_en = 1'b1;
  logic                  dout_valid;
  logic                  dout_last;
  logic [D_width-1:0]    dx;
  logic [D_width-1:0]    dy;
  logic [7:0]            lu;
  logic [7:0]            ru;
  logic [7:0]            ld;
  logic [7:0]            rd;

  interp_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .coord_valid (coord_valid),
    .coord_ready (coord_ready),
    .coord_last  (coord_last),
    .coord_x     (coord_x),
    .coord_y     (coord_y),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_data    (mem_data),
    .out_en      (out_en),
    .dout_valid  (dout_valid),
    .dout_last   (dout_last),
    .dx          (dx),
    .dy          (dy),
    .lu          (lu),
    .ru          (ru),
    .ld          (ld),
    .rd          (rd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame memory: pixel value is address mod 251, one-cycle read latency.
  always @(posedge clk) if (mem_rd) mem_data <= 8'(int'(mem_addr) % 251);

  typedef struct {
    int addr;
    int cyc;
  } exp_rd_t;

  typedef struct {
    int dx, dy, last;
    int lu, ru, ld, rd;
    int acc;
    int gap;
    int hold;
  } exp_out_t;

  exp_rd_t  addr_q[$];
  exp_out_t out_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  int drv_errs  = 0;
  bit rand_mode = 1'b0;
  bit end_chk   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  int rel_cnt    = 0;
  bit prev_valid = 1'b0;
  bit ready_next = 1'b0;
  int rise_cyc   = 0;
  int last_xfer  = 0;
  int drv_seen   = 0;
  bit end_done   = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_coord_ready", 32'(coord_ready), 0);
      check("rst_mem_rd", 32'(mem_rd), 0);
      check("rst_mem_addr", 32'(mem_addr), 0);
      check("rst_dout_valid", 32'(dout_valid), 0);
      check("rst_dout_last", 32'(dout_last), 0);
      check("rst_pixels", {lu, ru, ld, rd}, 0);
      check("rst_dxdy", 32'({dx, dy}), 0);
      addr_q.delete();
      out_q.delete();
      rel_cnt    = 0;
      prev_valid = 1'b0;
      ready_next = 1'b0;
    end else begin
      if (rel_cnt < 3) rel_cnt++;
      if (rel_cnt == 1) check("ready_before_first_clk", 32'(coord_ready), 0);
      else if (rel_cnt == 2) check("ready_after_release", 32'(coord_ready), 1);

      if (ready_next) begin
        check("ready_after_xfer", 32'(coord_ready), 1);
        ready_next = 1'b0;
      end

      if (mem_rd) begin
        if (addr_q.size() == 0) check("unexpected_mem_rd", 1, 0);
        else begin
          exp_rd_t a;
          a = addr_q.pop_front();
          check("mem_addr", 32'(mem_addr), a.addr);
          check("mem_rd_cycle", cyc, a.cyc);
        end
      end

      if (dout_valid) begin
        if (out_q.size() == 0) check("unexpected_dout_valid", 1, 0);
        else begin
          exp_out_t e;
          e = out_q[0];
          if (!prev_valid) begin
            rise_cyc = cyc;
            check("dout_valid_latency", cyc, e.acc + 6);
          end
          check("dx", 32'(dx), e.dx);
          check("dy", 32'(dy), e.dy);
          check("dout_last", 32'(dout_last), e.last);
          check("lu", 32'(lu), e.lu);
          check("ru", 32'(ru), e.ru);
          check("ld", 32'(ld), e.ld);
          check("rd", 32'(rd), e.rd);
          check("ready_low_in_out", 32'(coord_ready), 0);
          if (out_en) begin
            void'(out_q.pop_front());
            if (e.gap != 0) check("xfer_spacing", cyc - last_xfer, 7);
            if (e.hold >= 0) check("xfer_after_hold", cyc, rise_cyc + e.hold);
            last_xfer  = cyc;
            ready_next = 1'b1;
          end
        end
      end
      prev_valid = dout_valid;

      if (drv_errs != drv_seen) begin
        check("driver_timeout", drv_errs, drv_seen);
        drv_seen = drv_errs;
      end
      if (end_chk && !end_done) begin
        check("addr_q_drained", addr_q.size(), 0);
        check("out_q_drained", out_q.size(), 0);
        end_done = 1'b1;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mode) out_en = ($urandom_range(0, 3) != 0);
  endtask

  function automatic int clampv(input int v, input int hi);
    return (v > hi) ? hi : v;
  endfunction

  // Reference model: clamp, form the four addresses and pixel values.
  task automatic push_expect(input int xi, input int yi, input int fx, input int fy,
                             input int last, input int gap, input int hold, input int acc);
    int x0, x1, y0, y1;
    int a[4];
    exp_out_t e;
    x0 = clampv(xi, IMG_W - 1);
    x1 = clampv(x0 + 1, IMG_W - 1);
    y0 = clampv(yi, IMG_H - 1);
    y1 = clampv(y0 + 1, IMG_H - 1);
    a[0] = y0 * IMG_W + x0;
    a[1] = y0 * IMG_W + x1;
    a[2] = y1 * IMG_W + x0;
    a[3] = y1 * IMG_W + x1;
    for (int k = 0; k < 4; k++) addr_q.push_back('{addr: a[k], cyc: acc + 1 + k});
    e.dx = fx; e.dy = fy; e.last = last;
    e.lu = a[0] % 251; e.ru = a[1] % 251; e.ld = a[2] % 251; e.rd = a[3] % 251;
    e.acc = acc; e.gap = gap; e.hold = hold;
    out_q.push_back(e);
  endtask

  task automatic send(input int xi, input int yi, input int fx, input int fy,
                      input int last, input int gap, input int hold);
    bit done;
    done        = 1'b0;
    coord_x     = {xi[XW-1:0], fx[D_width-1:0]};
    coord_y     = {yi[YW-1:0], fy[D_width-1:0]};
    coord_last  = last[0];
    coord_valid = 1'b1;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      if (coord_ready) begin
        push_expect(xi % (1 << XW), yi % (1 << YW), fx % (1 << D_width),
                    fy % (1 << D_width), last, gap, hold, cyc);
        done = 1'b1;
      end
      tick();
    end
    coord_valid = 1'b0;
    if (!done) drv_errs++;
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 3000 && !done; n++) begin
      tick();
      done = (addr_q.size() == 0) && (out_q.size() == 0) && !dout_valid && !mem_rd;
    end
    if (!done) drv_errs++;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) tick();

    // Interior point, edge, and out-of-range clamp.
    send((100 << 6) >> 6, 50, 16, 40, 0, 0, -1);
    wait_drain();
    send(639, 479, 5, 9, 1, 0, -1);
    wait_drain();
    send(1000, 511, 33, 62, 0, 0, -1);
    wait_drain();

    // Backpressure: ten stalled cycles after dout_valid rises.
    out_en = 1'b0;
    send(200, 100, 7, 21, 0, 0, 10);
    for (int n = 0; n < 50 && !dout_valid; n++) tick();
    if (!dout_valid) drv_errs++;
    repeat (10) tick();
    out_en = 1'b1;
    wait_drain();

    // Three back-to-back coordinates, last on the third.
    send(10, 20, 1, 2, 0, 0, -1);
    send(11, 20, 3, 4, 0, 1, -1);
    send(12, 21, 5, 6, 1, 1, -1);
    wait_drain();

    // Reset while the FSM sits in RD2.
    send(300, 200, 9, 9, 0, 0, -1);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    wait_drain();

    // Randomized coordinates with random downstream stalls.
    rand_mode = 1'b1;
    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) tick();
      send($urandom_range(0, 1023), $urandom_range(0, 511), $urandom_range(0, 63),
           $urandom_range(0, 63), $urandom_range(0, 1), 0, -1);
    end
    rand_mode = 1'b0;
    out_en    = 1'b1;
    wait_drain();

    end_chk = 1'b1;
    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
